// File: rtl/srl_fifo4_pkg.sv
// Constants shared by every block built on addressable shift-register storage.
// The SRL primitive is always 32 words deep, so its address is always 5 bits wide.
package srl_fifo4_pkg;

   localparam int SRL_AW        = 5;
   localparam int SRL_MAX_DEPTH = 32;

endpackage : srl_fifo4_pkg

// File: rtl/srl_fifo4_srl_store.sv
// W-wide addressable shift register, one 32-bit shift chain per data bit.
// There is no reset, so each chain maps onto a single SRL32 primitive.
module srl_fifo4_srl_store
   import srl_fifo4_pkg::*;
#(
   parameter int W = 4
) (
   input  logic              clk,
   input  logic [W-1:0]      d,
   input  logic [SRL_AW-1:0] a,
   input  logic              ce,
   output logic [W-1:0]      y
);

   logic [SRL_MAX_DEPTH-1:0] sr_r [W];

   for (genvar b = 0; b < W; b++) begin : g_bit
      // Shift storage: the newest word enters at address 0.
      always_ff @(posedge clk) begin
         if (ce) begin
            sr_r[b] <= {sr_r[b][SRL_MAX_DEPTH-2:0], d[b]};
         end
      end

      assign y[b] = sr_r[b][a];
   end

endmodule : srl_fifo4_srl_store

// File: rtl/srl_fifo4.sv
// Synchronous FIFO: addressable SRL storage plus one registered output stage.
// The oldest stored word always sits at SRL address cnt-1.
module srl_fifo4
   import srl_fifo4_pkg::*;
#(
   parameter int W     = 4,
   parameter int DEPTH = 32,
   parameter int AW    = SRL_AW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [W-1:0]  din,
   input  logic          din_v,
   output logic          din_rdy,
   output logic [W-1:0]  dout,
   output logic          dout_v,
   input  logic          dout_rdy,
   output logic [AW:0]   lvl,
   output logic          ovf
);

   localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] CNT_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

   logic [AW:0]   cnt_r;
   logic [W-1:0]  dout_r;
   logic          dout_v_r;
   logic          ovf_r;

   logic          din_rdy_s;
   logic          push_s;
   logic          pop_s;
   logic          ld_s;
   logic          ce_s;
   logic [AW:0]   cnt_m1_s;
   logic [AW:0]   cnt_nxt_s;
   logic [AW-1:0] rd_addr_s;
   logic [W-1:0]  rd_data_s;

   // Handshake, load decision and next fill count.
   always_comb begin
      din_rdy_s = (cnt_r != CNT_DEPTH);
      push_s    = din_v & din_rdy_s;
      pop_s     = dout_v_r & dout_rdy;
      ld_s      = (cnt_r != CNT_ZERO) & (~dout_v_r | dout_rdy);
      ce_s      = push_s & rstn;
      cnt_m1_s  = cnt_r - CNT_ONE;
      rd_addr_s = cnt_m1_s[AW-1:0];
      cnt_nxt_s = cnt_r;
      case ({push_s, ld_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nxt_s = cnt_m1_s;
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   srl_fifo4_srl_store #(
      .W (W)
   ) u_store (
      .clk (clk),
      .d   (din),
      .a   (rd_addr_s),
      .ce  (ce_s),
      .y   (rd_data_s)
   );

   // Fill counter, output stage and sticky overflow; the read uses pre-edge cnt.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_r    <= CNT_ZERO;
         dout_r   <= {W{1'b0}};
         dout_v_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         if (ld_s) begin
            dout_r   <= rd_data_s;
            dout_v_r <= 1'b1;
         end else if (pop_s) begin
            dout_v_r <= 1'b0;
         end
         if (din_v && !din_rdy_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign din_rdy = din_rdy_s;
   assign dout    = dout_r;
   assign dout_v  = dout_v_r;
   assign ovf     = ovf_r;
   assign lvl     = cnt_r + {{AW{1'b0}}, dout_v_r};

endmodule : srl_fifo4
